// File: rtl/tick_uart_tx.sv
// tick_uart_tx: counts timer tick strobes and sends each new 8-bit count
// as a UART 8N1 frame on txd. A one-deep pending flag holds a tick that
// arrives while a frame is in flight; further ticks raise overrun.
module tick_uart_tx #(
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  output logic       txd,
  output logic       busy,
  output logic [7:0] count,
  output logic       overrun
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic          pending;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    count_next;
  logic          bit_end;

  // Post-increment count and end-of-bit-period detect
  always_comb begin
    count_next = count + {7'd0, tick};
    bit_end    = (baud_cnt == BAUD_LAST);
  end

  // Tick counter, pending/overrun tracking and the frame state machine
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      count    <= '0;
      overrun  <= 1'b0;
      pending  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      count   <= count_next;
      // A tick while a frame is running and one is already queued is lost
      overrun <= tick && (state != S_IDLE) && pending;

      case (state)
        S_IDLE: begin
          if (tick) begin
            shreg    <= count_next;
            state    <= S_START;
            busy     <= 1'b1;
            txd      <= 1'b0;
            baud_cnt <= '0;
          end
        end

        S_START: begin
          if (tick) pending <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        S_DATA: begin
          if (tick) pending <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            pending  <= 1'b0;
            // A tick on this very edge is treated as pending; the frame
            // payload is the post-increment count either way.
            if (pending || tick) begin
              shreg <= count_next;
              state <= S_START;
              txd   <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
            if (tick) pending <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
